donkey_ctl: RTL

DONKEY_CTL -- requirements
Module: donkey_ctl

---
 rtl/character_pkg.sv | 13 +
 rtl/vga_pkg.sv | 6 +
 rtl/donkey_ctl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/character_pkg.sv
// Sprite geometry and the donkey motion state encoding.
// Shared by the character controllers and the draw path.
package character_pkg;
  localparam int DONKEY_WIDTH  = 64;
  localparam int DONKEY_HEIGHT = 64;

  typedef enum logic [1:0] {
    IDLE,
    GROUND,
    JUMP,
    FALL
  } donkey_state_t;
endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants shared across the video path.
// Visible area of the 1024x768 mode.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/donkey_ctl.sv
// Donkey sprite controller: per-frame walk, jump and gravity.
// Motion advances once per rising edge of vblnk.
module donkey_ctl
  import vga_pkg::*;
  import character_pkg::*;
#(
  parameter int H_STEP   = 2,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 16,
  parameter int GROUND_Y = 700,
  parameter int X_START  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        left,
  input  logic        right,
  input  logic        jump,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        rotate
);

  localparam logic signed [12:0] X_MAX = 13'(HOR_PIXELS - DONKEY_WIDTH);
  localparam logic signed [12:0] HS    = 13'(H_STEP);
  localparam logic signed [12:0] GY    = 13'(GROUND_Y);
  localparam logic signed [7:0]  V0    = 8'(JUMP_V0);
  localparam logic signed [7:0]  GR    = 8'(GRAVITY);
  localparam logic signed [7:0]  VM    = 8'(V_MAX);

  donkey_state_t state, state_nxt;

  logic              vblnk_q;
  logic              tick;
  logic signed [7:0] vel, vel_nxt;
  logic signed [7:0] v_dec, v_inc;
  logic [11:0]       xpos_nxt, ypos_nxt;
  logic              rotate_nxt, rot_mv;
  logic signed [12:0] x_mv, y_up, y_dn;

  assign tick = vblnk & ~vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      vel     <= '0;
      xpos    <= 12'(X_START);
      ypos    <= 12'(GROUND_Y);
      rotate  <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      vel     <= vel_nxt;
      xpos    <= xpos_nxt;
      ypos    <= ypos_nxt;
      rotate  <= rotate_nxt;
    end
  end

  // Vertical candidates; fall speed saturates at V_MAX.
  always_comb begin
    v_dec = vel - GR;
    v_inc = ((vel + GR) > VM) ? VM : (vel + GR);
    y_up  = $signed({1'b0, ypos}) - $signed({{5{vel[7]}}, vel});
    y_dn  = $signed({1'b0, ypos}) + $signed({{5{v_inc[7]}}, v_inc});
  end

  always_comb begin
    x_mv   = $signed({1'b0, xpos});
    rot_mv = rotate;
    if (left && !right) begin
      x_mv   = x_mv - HS;
      rot_mv = 1'b1;
      if (x_mv < 13'sd0) x_mv = 13'sd0;
    end else if (right && !left) begin
      x_mv   = x_mv + HS;
      rot_mv = 1'b0;
      if (x_mv > X_MAX) x_mv = X_MAX;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && !start_game) begin
      state_nxt = IDLE;
    end else if (tick) begin
      case (state)
        IDLE:   if (start_game) state_nxt = GROUND;
        GROUND: if (jump) state_nxt = JUMP;
        JUMP:   if (y_up < 13'sd0 || v_dec <= 8'sd0) state_nxt = FALL;
        FALL:   if (y_dn >= GY) state_nxt = GROUND;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    vel_nxt    = vel;
    xpos_nxt   = xpos;
    ypos_nxt   = ypos;
    rotate_nxt = rotate;
    if (state == IDLE || !start_game) begin
      vel_nxt    = '0;
      xpos_nxt   = 12'(X_START);
      ypos_nxt   = 12'(GROUND_Y);
      rotate_nxt = 1'b0;
    end else if (tick) begin
      xpos_nxt   = 12'(x_mv);
      rotate_nxt = rot_mv;
      case (state)
        GROUND: if (jump) vel_nxt = V0;
        JUMP: begin
          if (y_up < 13'sd0) begin
            ypos_nxt = '0;
            vel_nxt  = '0;
          end else begin
            ypos_nxt = 12'(y_up);
            vel_nxt  = (v_dec <= 8'sd0) ? 8'sd0 : v_dec;
          end
        end
        FALL: begin
          if (y_dn >= GY) begin
            ypos_nxt = 12'(GY);
            vel_nxt  = '0;
          end else begin
            ypos_nxt = 12'(y_dn);
            vel_nxt  = v_inc;
          end
        end
        default: vel_nxt = vel;
      endcase
    end
  end

endmodule
